// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle integer multiply/divide unit.
// Multiplies complete in a single MUL cycle. Divides use a restoring radix-2
// loop: one setup cycle (special-case detection and conversion to magnitudes),
// then one quotient bit per cycle for XLEN cycles. The result is registered on
// entry to DONE, where valid pulses for one cycle.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [2:0]      mdcode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;      // low mdcode bits; state tells MUL from DIV
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;        // partial remainder
    logic [XLEN-1:0] quo_q, quo_d;        // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dvs_q, dvs_d;        // divisor magnitude
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] result_q, result_d;

    // Magnitude of a value, treating it as two's complement only when signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // Conditional two's-complement negation, used for the final sign fix-up.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Multiplier: operands sign- or zero-extended to 2*XLEN, product taken mod 2^(2*XLEN)
    logic                   mul_a_sgn, mul_b_sgn;
    logic signed [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic [XLEN-1:0]        mul_res;

    always_comb begin
        mul_a_sgn = a_q[XLEN-1] && (code_q != 2'd3);
        mul_b_sgn = b_q[XLEN-1] && (code_q == 2'd1 || code_q == 2'd0);
        mul_a     = {{XLEN{mul_a_sgn}}, a_q};
        mul_b     = {{XLEN{mul_b_sgn}}, b_q};
        mul_p     = mul_a * mul_b;
        mul_res   = (code_q == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end

    // One restoring-division step plus special-case detection
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nx, quo_nx;
    logic            div_sgn, div_zero, div_ovf;

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        q_bit    = ~rem_diff[XLEN];
        rem_nx   = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx   = {quo_q[XLEN-2:0], q_bit};
        div_sgn  = ~code_q[0];
        div_zero = (b_q == '0);
        div_ovf  = div_sgn && (a_q == MOST_NEG) && (b_q == '1);
    end

    // State register and iteration counter
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = mdcode[2] ? S_DIV : S_MUL;
            S_MUL:  state_d = S_DONE;
            S_DIV: begin
                if (cnt_q == '0) begin
                    if (div_zero || div_ovf) state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; result comes straight from its register
    always_comb begin
        busy   = (state_q == S_MUL) || (state_q == S_DIV);
        valid  = (state_q == S_DONE);
        result = result_q;
    end

    // Datapath next values: operand capture, multiply, divide setup and steps
    always_comb begin
        code_d   = code_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        cnt_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    code_d = mdcode[1:0];
                    a_d    = op1;
                    b_d    = op2;
                end
            end
            S_MUL: result_d = mul_res;
            S_DIV: begin
                if (cnt_q == '0) begin
                    if (div_zero) begin
                        result_d = code_q[1] ? a_q : '1;
                    end else if (div_ovf) begin
                        result_d = code_q[1] ? '0 : a_q;
                    end else begin
                        rem_d  = '0;
                        quo_d  = mag(a_q, div_sgn);
                        dvs_d  = mag(b_q, div_sgn);
                        negq_d = div_sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                        negr_d = div_sgn && a_q[XLEN-1];
                        cnt_d  = cnt_q + 1'b1;
                    end
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = code_q[1] ? cond_neg(rem_nx, negr_q)
                                             : cond_neg(quo_nx, negq_q);
                    end
                end
            end
            default: ;
        endcase
    end

    // Result register: cleared by reset, loaded only on entry to DONE
    always_ff @(posedge clk) begin
        if (!nrst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    // Working registers; contents are don't-care until an operation is accepted
    always_ff @(posedge clk) begin
        code_q <= code_d;
        a_q    <= a_d;
        b_q    <= b_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (XLEN=32): directed vector table, hand-written
// multi-cycle sequences (ignored start while busy, reset abort) and random
// operations compared against an arithmetic reference model.
module tb_alu_muldiv;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [2:0]  mdcode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    alu_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .mdcode (mdcode),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit / native-integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c < 3'd4 || b == 0) return 2;
        if ((c == 3'd4 || c == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Issue one op from IDLE (called #1 after a rising edge). Returns the result
    // seen in the valid cycle and the cycle number of valid (start cycle = 0).
    // Leaves the DUT in IDLE so the caller's next start is accepted.
    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        mdcode = c;
        op1    = a;
        op2    = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        mdcode = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
        lat    = 1;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        while (!valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        if (!valid) lat = -1;
        @(posedge clk); #1;
        chk("valid_one_cycle", {31'h0, valid}, 32'h0);
    endtask

    vec_t        vecs[$];
    logic [31:0] res, prev;
    int          lat;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        nrst   = 1'b0;
        start  = 1'b0;
        mdcode = 3'd0;
        op1    = 32'h0;
        op2    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        chk("reset_busy",   {31'h0, busy},  32'h0);
        chk("reset_valid",  {31'h0, valid}, 32'h0);
        chk("reset_result", result,         32'h0);

        // Directed vectors
        vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2});
        vecs.push_back('{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2});
        vecs.push_back('{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 2});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2});
        vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34});
        vecs.push_back('{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 34});
        vecs.push_back('{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 34});
        vecs.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk_int($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // DIVU 100/7 with a MUL start pulsed while busy: must be ignored
        prev   = result;
        mdcode = 3'd5;
        op1    = 32'd100;
        op2    = 32'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        mdcode = 3'd0;
        op1    = 32'd3;
        op2    = 32'd3;
        start  = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        chk("hold_result_while_busy", result, prev);
        while (!valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk_int("ignored_start_latency", lat, 34);
        chk("ignored_start_result", result, 32'd14);
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd3, res, lat);
        chk("after_busy_mul_result", res, 32'd9);
        chk_int("after_busy_mul_latency", lat, 2);

        // Reset mid-DIV, with start held during reset
        mdcode = 3'd4;
        op1    = 32'h1234_5678;
        op2    = 32'd3;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        nrst   = 1'b0;
        start  = 1'b1;
        mdcode = 3'd0;
        @(posedge clk); #1;
        nrst  = 1'b1;
        start = 1'b0;
        chk("abort_busy",   {31'h0, busy},  32'h0);
        chk("abort_result", result,         32'h0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid || busy) lat++;
        end
        chk_int("abort_no_valid_or_busy", lat, 0);
        run_op(3'd0, 32'd2, 32'd3, res, lat);
        chk("post_reset_mul_result", res, 32'd6);
        chk_int("post_reset_mul_latency", lat, 2);

        // Random operations against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  c;
            logic [31:0] a, b;
            c = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(c, a, b, res, lat);
            chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, c, a, b), res, model(c, a, b));
            chk_int($sformatf("rnd%0d_op%0d_latency", i, c), lat, model_lat(c, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits (even, >=8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request strobe; sampled only when busy=0.
REQ-005 SHALL have port mdcode  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port op1  input  XLEN  first operand (dividend / multiplicand).
REQ-007 SHALL have port op2  input  XLEN  second operand (divisor / multiplier).
REQ-008 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-009 SHALL have port valid  output  1  one-cycle pulse: result is valid this cycle.
REQ-010 SHALL have port result  output  XLEN  registered result.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-012 IDLE: start=1 latches mdcode, op1, op2 and sets busy=1 in the same edge; next state MUL for mdcode 0-3, DIV for 4-7.
REQ-013 start while busy=1 SHALL be ignored; latched operands and mdcode SHALL NOT change.
REQ-014 MUL: one cycle; forms the 2*XLEN product. MUL returns low XLEN bits. MULH returns high bits, signed x signed. MULHSU returns high bits, signed op1 x unsigned op2. MULHU returns high bits, unsigned x unsigned. Next state DONE.
REQ-015 DIV: restoring radix-2, one quotient bit per cycle, exactly XLEN iteration cycles on unsigned magnitudes; then next state DONE.
REQ-016 Signed DIV/REM: operands converted to magnitudes before iterating. Quotient negated if operand signs differ. Remainder takes the sign of op1.
REQ-017 Divide by zero (op2=0) SHALL skip iteration (DIV state lasts 1 cycle). Quotient = all ones (DIV and DIVU). Remainder = op1 (REM and REMU).
REQ-018 Signed overflow (DIV/REM, op1=most negative, op2=all ones) SHALL skip iteration (1 cycle). Quotient = op1. Remainder = 0.
REQ-019 DONE: result register loaded; valid=1 for exactly this cycle; busy=0; next state IDLE.
REQ-020 start SHALL be accepted in the cycle after DONE; back-to-back operations allowed, no bubble beyond IDLE.
REQ-021 Latency from start edge to valid cycle SHALL be:
- 2 cycles for MUL ops;
- XLEN+2 cycles for normal DIV ops;
- 2 cycles for divide-by-zero/overflow.
REQ-022 result SHALL hold its value from DONE until the next DONE.
REQ-023 busy SHALL be 1 in MUL and DIV states, 0 in IDLE and DONE.
REQ-024 All arithmetic SHALL be modulo 2^XLEN on outputs; no exceptions or flags are raised.

Reset
REQ-025 nrst=0 at a rising edge SHALL force state IDLE, busy=0, valid=0, result=0, and clear the iteration counter.
REQ-026 Reset mid-operation SHALL abort it; no valid pulse SHALL follow for the aborted operation.
REQ-027 start asserted in a cycle with nrst=0 SHALL be ignored.

Verification (XLEN=32)
REQ-028 MUL, op1=7, op2=0xFFFFFFFD -> valid 2 cycles after start, result=0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 DIV, op1=0xFFFFFFF9 (-7), op2=2 -> busy 33 cycles, valid at cycle 34, result=0xFFFFFFFD. Same operands with REM -> 0xFFFFFFFF.
REQ-030 DIVU 5/0 -> result=0xFFFFFFFF at cycle 2; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-031 DIVU 100/7 started; start with MUL 3x3 pulsed at cycle 5 -> ignored, result=14 at cycle 34, then MUL accepted in the following cycle -> 9.
REQ-032 DIV started, nrst=0 at cycle 10 -> busy=0, result=0, no valid for 40 cycles. New MUL 2x3 after reset -> 6 at cycle 2.
